// File: rtl/softmax_r2b_dispatcher_pkg.sv
// Shared types and helpers for the softmax-to-R2B row dispatcher.
package softmax_r2b_dispatcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } disp_state_t;

    // Index width for an N-entry vector; never below one bit.
    function automatic int unsigned row_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softmax_r2b_dispatcher_if.sv
// Row-side and lane-side handshake bundle between softmax rows, dispatcher and R2B lanes.
interface softmax_r2b_dispatcher_if #(
    parameter int unsigned NUM_ROWS  = 4,
    parameter int unsigned NUM_LANES = 2
);
    import softmax_r2b_dispatcher_pkg::*;

    localparam int unsigned ROW_W = row_idx_w(NUM_ROWS);

    logic [NUM_ROWS-1:0]             row_valid;
    logic [NUM_ROWS-1:0]             row_ready;
    logic [NUM_LANES-1:0]            lane_valid;
    logic [NUM_LANES-1:0]            lane_ready;
    logic [NUM_LANES-1:0][ROW_W-1:0] lane_row_idx;
    logic [NUM_LANES-1:0]            lane_slice_last;
    logic [NUM_LANES-1:0]            lane_rst_n;

    modport master (
        input  row_valid, lane_ready, lane_slice_last,
        output row_ready, lane_valid, lane_row_idx, lane_rst_n
    );

    modport slave (
        output row_valid, lane_ready, lane_slice_last,
        input  row_ready, lane_valid, lane_row_idx, lane_rst_n
    );

endinterface

// File: rtl/softmax_r2b_dispatcher_rr_arbiter.sv
// Round-robin one-hot grant: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);
    always_comb begin
        logic [PTR_W:0] idx;
        logic           found;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(N)) idx = idx - (PTR_W + 1)'(N);
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/softmax_r2b_dispatcher.sv
// Round-robin dispatch of softmax rows onto R2B lanes with per-lane beat counting.
// Optional stall counter enabled by defining SOFTMAX_DISP_PERF_EN.
module softmax_r2b_dispatcher
    import softmax_r2b_dispatcher_pkg::*;
#(
    parameter int unsigned NUM_ROWS      = 4,
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned TILES_PER_ROW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    softmax_r2b_dispatcher_if.master bus,
    output logic                     busy,
    output logic                     slice_done,
    output logic [31:0]              stall_cycles
);
    localparam int unsigned ROW_W  = row_idx_w(NUM_ROWS);
    localparam int unsigned BEAT_W = $clog2(TILES_PER_ROW + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TILES_PER_ROW - 1);

    disp_state_t state, state_nxt;

    logic [NUM_ROWS-1:0]              row_done, row_assigned, row_req, row_rdy, grant;
    logic [NUM_LANES-1:0]             lane_active, lane_used, last_seen, lane_rst_q;
    logic [NUM_LANES-1:0]             lane_vld, beat, lane_last, free_lane;
    logic [NUM_LANES-1:0][ROW_W-1:0]  row_idx;
    logic [NUM_LANES-1:0][BEAT_W-1:0] beat_cnt;
    logic [ROW_W-1:0]                 rr_ptr, win_idx, ptr_nxt;
    logic                             assign_en, flush_ok;

    always_comb begin
        lane_vld     = '0;
        row_rdy      = '0;
        beat         = '0;
        lane_last    = '0;
        row_assigned = '0;
        for (int unsigned m = 0; m < NUM_LANES; m++) begin
            if (lane_active[m]) begin
                row_assigned[row_idx[m]] = 1'b1;
                lane_vld[m] = bus.row_valid[row_idx[m]];
            end
            beat[m] = lane_vld[m] & bus.lane_ready[m];
            if (beat[m]) row_rdy[row_idx[m]] = 1'b1;
            lane_last[m] = beat[m] && (beat_cnt[m] == LAST_BEAT);
        end
    end

    assign row_req = (state == RUN) ? (bus.row_valid & ~row_done & ~row_assigned) : '0;

    rr_arbiter #(.N(NUM_ROWS), .PTR_W(ROW_W)) u_row_arb (
        .req   (row_req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Lanes still busy this cycle are never candidates, so a lane freed by its
    // last beat can only be reassigned on the following cycle.
    always_comb begin
        logic found;
        found     = 1'b0;
        free_lane = '0;
        for (int unsigned m = 0; m < NUM_LANES; m++) begin
            if (!lane_active[m] && !found) begin
                free_lane[m] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        win_idx = '0;
        for (int unsigned r = 0; r < NUM_ROWS; r++)
            if (grant[r]) win_idx = ROW_W'(r);
    end

    assign assign_en = (|grant) & (|free_lane);
    assign ptr_nxt   = (win_idx == ROW_W'(NUM_ROWS - 1)) ? '0 : win_idx + 1'b1;
    assign flush_ok  = &(~lane_used | last_seen | bus.lane_slice_last);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (&row_done) state_nxt = FLUSH;
            FLUSH:   if (flush_ok) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_done    <= '0;
            lane_active <= '0;
            lane_used   <= '0;
            last_seen   <= '0;
            row_idx     <= '0;
            beat_cnt    <= '0;
            rr_ptr      <= '0;
            lane_rst_q  <= '0;
        end else begin
            lane_rst_q <= ~bus.lane_slice_last;
            if (state == RUN || state == FLUSH) last_seen <= last_seen | bus.lane_slice_last;
            if (assign_en) rr_ptr <= ptr_nxt;
            for (int unsigned m = 0; m < NUM_LANES; m++) begin
                if (lane_last[m]) begin
                    lane_active[m]       <= 1'b0;
                    beat_cnt[m]          <= '0;
                    row_done[row_idx[m]] <= 1'b1;
                end else if (beat[m]) begin
                    beat_cnt[m] <= beat_cnt[m] + 1'b1;
                end else if (assign_en && free_lane[m]) begin
                    lane_active[m] <= 1'b1;
                    lane_used[m]   <= 1'b1;
                    row_idx[m]     <= win_idx;
                end
            end
            if (state == DONE) begin
                row_done  <= '0;
                lane_used <= '0;
                last_seen <= '0;
                beat_cnt  <= '0;
            end
        end
    end

`ifdef SOFTMAX_DISP_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else if (state == IDLE && start)
            stall_q <= '0;
        else if (state == RUN && |(lane_vld & ~bus.lane_ready) && stall_q != '1)
            stall_q <= stall_q + 1'b1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign bus.lane_valid   = lane_vld;
    assign bus.row_ready    = row_rdy;
    assign bus.lane_row_idx = row_idx;
    assign bus.lane_rst_n   = lane_rst_q;
    assign busy             = (state != IDLE);
    assign slice_done       = (state == DONE);

endmodule

// File: tb/tb_softmax_r2b_dispatcher.sv
// Randomised and directed bench for softmax_r2b_dispatcher against a round-robin dispatch model.
module tb_softmax_r2b_dispatcher;
    localparam int NR  = 4;
    localparam int NL  = 2;
    localparam int TPR = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, slice_done;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    softmax_r2b_dispatcher_if #(.NUM_ROWS(NR), .NUM_LANES(NL)) bus ();

    softmax_r2b_dispatcher #(.NUM_ROWS(NR), .NUM_LANES(NL), .TILES_PER_ROW(TPR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .slice_done   (slice_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Observation state, sampled on the falling edge.
    int cyc = 0;
    int beats [NR];
    int first_lane [NR];
    int disp_q[$];
    int disp_lane[$];
    int viol, stall_cnt, done_cnt, done_cyc, tot_beats;
    int rst_bad = 0;
    bit prev_ok = 1'b0;
    bit prev_rst;
    logic [NL-1:0] prev_sl;
    int mdl_ptr = 0;

    task automatic clear_mon();
        for (int r = 0; r < NR; r++) begin
            beats[r]      = 0;
            first_lane[r] = -1;
        end
        disp_q.delete();
        disp_lane.delete();
        viol = 0; stall_cnt = 0; done_cnt = 0; done_cyc = -1; tot_beats = 0;
    endtask

    always @(negedge clk) begin
        int nb, nr, r;
        logic [NL-1:0] exp_lr;
        cyc++;
        nb = 0;
        nr = 0;
        for (int m = 0; m < NL; m++) begin
            r = int'(bus.lane_row_idx[m]);
            if (bus.lane_valid[m] && !bus.row_valid[r]) viol++;
            if (bus.lane_valid[m] && bus.lane_ready[m]) begin
                nb++;
                if (!bus.row_ready[r]) viol++;
                if (first_lane[r] < 0) begin
                    first_lane[r] = m;
                    disp_q.push_back(r);
                    disp_lane.push_back(m);
                end
            end
            for (int n = m + 1; n < NL; n++)
                if (bus.lane_valid[m] && bus.lane_valid[n] && bus.lane_row_idx[m] == bus.lane_row_idx[n]) viol++;
        end
        if (|(bus.lane_valid & ~bus.lane_ready)) stall_cnt++;
        for (int q = 0; q < NR; q++) begin
            if (bus.row_ready[q]) begin
                nr++;
                beats[q]++;
                if (!bus.row_valid[q]) viol++;
            end
        end
        if (nr != nb) viol++;
        tot_beats += nb;
        if (slice_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_ok) begin
            exp_lr = prev_rst ? ~prev_sl : '0;
            if (bus.lane_rst_n !== exp_lr) rst_bad++;
        end
        prev_ok  = 1'b1;
        prev_rst = rst_n;
        prev_sl  = bus.lane_slice_last;
    end

    task automatic drive(input int mode, input int k);
        case (mode)
            1: begin
                bus.row_valid     = '1;
                bus.lane_ready    = '1;
                bus.lane_ready[0] = k[0];
            end
            2: begin
                bus.row_valid  = '1;
                if (k < 20) begin
                    bus.row_valid         = '0;
                    bus.row_valid[NR - 1] = 1'b1;
                end
                bus.lane_ready = '1;
            end
            3: begin
                bus.row_valid  = NR'($urandom);
                bus.lane_ready = NL'($urandom);
            end
            default: begin
                bus.row_valid  = '1;
                bus.lane_ready = '1;
            end
        endcase
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_slice(input int mode, input int restart_beat);
        int base, last_sl;
        int slack [NL];
        bit restarted;
        clear_mon();
        bus.lane_slice_last = '0;
        for (int m = 0; m < NL; m++) slack[m] = (mode == 3) ? int'($urandom_range(0, 4)) : 0;
        drive(mode, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        restarted = 1'b0;
        base      = -1;
        last_sl   = -2;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            drive(mode, k);
            start = 1'b0;
            if (!restarted && tot_beats >= restart_beat) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (base < 0 && tot_beats == NR * TPR) base = k;
            bus.lane_slice_last = '0;
            if (base >= 0)
                for (int m = 0; m < NL; m++)
                    if (k == base + 2 + 3 * m + slack[m]) begin
                        bus.lane_slice_last[m] = 1'b1;
                        last_sl = cyc + 1;
                    end
            @(posedge clk); #1;
        end
        start = 1'b0;
        bus.lane_slice_last = '0;
        repeat (2) @(posedge clk);
        #1;
        check("slice_done_count", done_cnt, 1);
        check("slice_done_timing", done_cyc, last_sl + 1);
        check("busy_after_slice", busy, 0);
        for (int r = 0; r < NR; r++) check("row_beats", beats[r], TPR);
        check("handshake_violations", viol, 0);
        check("lane_rst_n_tracking", rst_bad, 0);
`ifdef SOFTMAX_DISP_PERF_EN
        check("stall_cycles", stall_cycles, stall_cnt);
`else
        check("stall_cycles", stall_cycles, 0);
`endif
    endtask

    // Expected first-beat order: optional early row, then rows in round-robin order.
    task automatic order_check(input int early, input bit lanes);
        int exp_q[$];
        int p;
        if (early >= 0) exp_q.push_back(early);
        p = (early >= 0) ? (early + 1) % NR : mdl_ptr;
        for (int i = 0; i < NR; i++)
            if ((p + i) % NR != early) exp_q.push_back((p + i) % NR);
        check("dispatch_count", disp_q.size(), NR);
        for (int i = 0; i < NR && i < disp_q.size(); i++) begin
            check("dispatch_row", disp_q[i], exp_q[i]);
            if (lanes || i == 0) check("dispatch_lane", disp_lane[i], lanes ? i % NL : 0);
        end
        mdl_ptr = (exp_q[NR - 1] + 1) % NR;
    endtask

    initial begin
        start               = 1'b1;
        bus.row_valid       = '1;
        bus.lane_ready      = '1;
        bus.lane_slice_last = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_lane_valid", bus.lane_valid, 0);
        check("reset_row_ready", bus.row_ready, 0);
        check("reset_slice_done", slice_done, 0);
        check("reset_lane_rst_n", bus.lane_rst_n, 0);
        check("reset_lane_row_idx", bus.lane_row_idx, 0);
        check("reset_stall", stall_cycles, 0);
        start               = 1'b0;
        bus.row_valid       = '0;
        bus.lane_ready      = '0;
        bus.lane_slice_last = '0;
        rst_n               = 1'b1;
        @(posedge clk); #1;

        run_slice(0, 1000);
        order_check(-1, 1'b1);

        run_slice(1, 1000);
        mdl_ptr = mdl_ptr;

        run_slice(2, 1000);
        order_check(NR - 1, 1'b0);

        run_slice(0, 12);
        order_check(-1, 1'b1);

        clear_mon();
        drive(0, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && tot_beats < 5; k++) begin
            @(posedge clk); #1;
        end
        check("reach_beat5", tot_beats >= 5, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_busy", busy, 0);
        check("midreset_lane_valid", bus.lane_valid, 0);
        check("midreset_row_ready", bus.row_ready, 0);
        for (int k = 0; k < 20; k++) begin
            bus.lane_slice_last = (k == 3) ? '1 : '0;
            @(posedge clk); #1;
        end
        bus.lane_slice_last = '0;
        check("midreset_no_done", done_cnt, 0);
        mdl_ptr = 0;
        run_slice(0, 1000);
        order_check(-1, 1'b1);

        for (int s = 0; s < 5; s++) run_slice(3, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
